// File: rtl/sram_burst_iface_if.sv
// Request/response bus and SRAM pin bundle for sram_burst_iface.
// The block sits on the slave side; the datapath controller is the master.
interface sram_burst_iface_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24,
    parameter int LEN_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              abort;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;

    modport master (
        output req_valid, req_write, req_addr, req_len, abort, wr_data,
        input  req_ready, wr_data_ack, rd_data, rd_valid, done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, abort, wr_data, r_data,
        output req_ready, wr_data_ack, rd_data, rd_valid, done,
               read_enable, write_enable, address, w_data
    );

    modport sram (
        input  read_enable, write_enable, address, w_data,
        output r_data
    );
endinterface

// File: rtl/sram_burst_iface.sv
// Burst SRAM access engine: each beat holds the SRAM for WAIT_CYCLES cycles,
// beats are separated by a one-cycle idle gap, and the address auto-increments.
module sram_burst_iface #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 24,
    parameter int WAIT_CYCLES = 12,
    parameter int LEN_W       = 3
) (
    input  logic clk,
    input  logic n_rst,
    sram_burst_iface_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_CYCLES - 1);

    state_t            state;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  beats_q;
    logic [7:0]        wait_q;
    logic [DATA_W-1:0] w_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            wait_q     <= '0;
            w_data_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q     <= bus.req_write;
                        addr_q   <= bus.req_addr;
                        beats_q  <= bus.req_len;
                        wait_q   <= '0;
                        w_data_q <= bus.req_write ? bus.wr_data : '0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Abort takes priority even on the final wait cycle.
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (wait_q == LAST_WAIT) begin
                        wait_q <= '0;
                        if (!wr_q) begin
                            rd_data_q  <= bus.r_data;
                            rd_valid_q <= 1'b1;
                        end
                        state <= (beats_q == '0) ? DONE : GAP;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                GAP: begin
                    if (wr_q) begin
                        w_data_q <= bus.wr_data;
                    end
                    if (bus.abort) begin
                        state <= IDLE;
                    end else begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        beats_q <= beats_q - LEN_W'(1);
                        state   <= ACCESS;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state alone; only the IDLE write ack sees inputs.
    assign bus.req_ready    = (state == IDLE);
    assign bus.read_enable  = (state == ACCESS) && !wr_q;
    assign bus.write_enable = (state == ACCESS) && wr_q;
    assign bus.done         = (state == DONE);
    assign bus.address      = addr_q;
    assign bus.w_data       = w_data_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.wr_data_ack  = n_rst &&
                              (((state == IDLE) && bus.req_valid && bus.req_write) ||
                               ((state == GAP) && wr_q));
endmodule

// File: tb/tb_sram_burst_iface.sv
// Bench for sram_burst_iface: cycle-offset reference model with randomized
// traffic plus directed bursts, wrap, abort, reset and WAIT_CYCLES=1 cases.
module tb_sram_burst_iface;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 24;
    localparam int LEN_W  = 3;
    localparam int W      = 12;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    sram_burst_iface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus0 ();
    sram_burst_iface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus1 ();

    sram_burst_iface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .n_rst(n_rst), .bus(bus0));
    sram_burst_iface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(1), .LEN_W(LEN_W)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM read data changes every cycle unless pinned.
    logic              rd_fix = 1'b0;
    logic [DATA_W-1:0] rd_fix_val = '0;
    always @(posedge clk) begin
        #1;
        bus0.r_data = rd_fix ? rd_fix_val : DATA_W'($urandom);
    end

    // Reference model: a burst accepted at cycle T puts cycle T+off at
    // beat (off-1)/(W+1), position (off-1)%(W+1); position W is the gap/done slot.
    bit                m_busy = 0;
    bit                m_w = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                m_len = 0;
    int                m_off = 0;
    logic [DATA_W-1:0] m_rd = '0;
    bit                m_rv = 0;
    logic [DATA_W-1:0] m_wq[$];
    bit e_ready, e_re, e_we, e_done, e_ack, acc;
    int k, pos, L;

    always @(negedge clk) begin
        if (!n_rst) begin
            chk("rst_ready", bus0.req_ready, 1);
            chk("rst_re", bus0.read_enable, 0);
            chk("rst_we", bus0.write_enable, 0);
            chk("rst_addr", bus0.address, 0);
            chk("rst_wdata", bus0.w_data, 0);
            chk("rst_rdata", bus0.rd_data, 0);
            chk("rst_rv", bus0.rd_valid, 0);
            chk("rst_done", bus0.done, 0);
            chk("rst_ack", bus0.wr_data_ack, 0);
            m_busy = 0;
            m_rv = 0;
            m_rd = '0;
        end else begin
            e_ready = !m_busy; e_re = 0; e_we = 0; e_done = 0; e_ack = 0; acc = 0;
            k = 0; pos = 0; L = 0;
            if (!m_busy) begin
                e_ack = bus0.req_valid && bus0.req_write;
            end else begin
                L   = m_len + 1;
                k   = (m_off - 1) / (W + 1);
                pos = (m_off - 1) % (W + 1);
                if (pos < W) begin
                    acc = 1; e_re = !m_w; e_we = m_w;
                end else if (k == L - 1) begin
                    e_done = 1;
                end else begin
                    e_ack = m_w;
                end
            end
            chk("m_ready", bus0.req_ready, e_ready);
            chk("m_re", bus0.read_enable, e_re);
            chk("m_we", bus0.write_enable, e_we);
            chk("m_done", bus0.done, e_done);
            chk("m_ack", bus0.wr_data_ack, e_ack);
            chk("m_rv", bus0.rd_valid, m_rv);
            chk("m_rdata", bus0.rd_data, m_rd);
            if (acc) begin
                chk("m_addr", bus0.address, ADDR_W'(m_addr + k));
                chk("m_wdata", bus0.w_data, m_w ? m_wq[k] : '0);
            end
            m_rv = 0;
            if (!m_busy) begin
                if (bus0.req_valid) begin
                    m_busy = 1; m_off = 1; m_w = bus0.req_write;
                    m_addr = bus0.req_addr; m_len = int'(bus0.req_len);
                    m_wq.delete();
                    if (m_w) m_wq.push_back(bus0.wr_data);
                end
            end else begin
                if (acc && pos == W - 1 && !bus0.abort && !m_w) begin
                    m_rv = 1;
                    m_rd = bus0.r_data;
                end
                if (!acc && k == L - 1) begin
                    m_busy = 0;
                end else if (bus0.abort) begin
                    m_busy = 0;
                end else begin
                    if (!acc && m_w) m_wq.push_back(bus0.wr_data);
                    m_off++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus0.req_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) chk("idle_timeout", 0, 1);
    endtask

    task automatic req(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len);
        bus0.req_valid = 1'b1;
        bus0.req_write = wr;
        bus0.req_addr  = a;
        bus0.req_len   = len;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    int acks, rvs;

    initial begin
        n_rst = 1'b0;
        bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = '0; bus0.req_len = '0;
        bus0.abort = 0; bus0.wr_data = '0;
        bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = '0; bus1.req_len = '0;
        bus1.abort = 0; bus1.wr_data = '0; bus1.r_data = 24'h0F0F0F;
        repeat (3) step();
        n_rst = 1'b1;
        step();

        // Single read, pinned read data.
        wait_idle();
        rd_fix = 1'b1; rd_fix_val = 24'hA5B6C7;
        req(1'b0, 16'h0040, 3'd0);
        step();
        bus0.req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("sr_re", bus0.read_enable, 1);
            chk("sr_addr", bus0.address, 16'h0040);
            step();
        end
        @(negedge clk);
        chk("sr_rv", bus0.rd_valid, 1);
        chk("sr_done", bus0.done, 1);
        chk("sr_rdata", bus0.rd_data, 24'hA5B6C7);
        step();
        @(negedge clk);
        chk("sr_ready", bus0.req_ready, 1);
        rd_fix = 1'b0;
        step();

        // Four-beat write burst.
        wait_idle();
        acks = 0;
        req(1'b1, 16'h1000, 3'd3);
        for (int c = 0; c <= 52; c++) begin
            bus0.wr_data = DATA_W'(32'h111111 * (acks + 1));
            @(negedge clk);
            chk("wb_ack", bus0.wr_data_ack, (c == 0 || c == 13 || c == 26 || c == 39));
            if (bus0.wr_data_ack === 1'b1) acks++;
            chk("wb_done", bus0.done, (c == 52));
            if (c >= 1) begin
                if ((c - 1) % 13 < 12) begin
                    chk("wb_we", bus0.write_enable, 1);
                    chk("wb_addr", bus0.address, 16'h1000 + (c - 1) / 13);
                    chk("wb_wdata", bus0.w_data, DATA_W'(32'h111111 * ((c - 1) / 13 + 1)));
                end else begin
                    chk("wb_gap_en", {bus0.write_enable, bus0.read_enable}, 0);
                end
            end
            step();
            if (c == 0) bus0.req_valid = 1'b0;
        end

        // Read burst across the address wrap.
        wait_idle();
        rvs = 0;
        req(1'b0, 16'hFFFE, 3'd3);
        for (int c = 0; c <= 52; c++) begin
            @(negedge clk);
            if (c >= 1 && (c - 1) % 13 == 0)
                chk("wr_addr", bus0.address, ADDR_W'(16'hFFFE + (c - 1) / 13));
            chk("wr_rv", bus0.rd_valid, (c > 0 && c % 13 == 0));
            if (bus0.rd_valid === 1'b1) rvs++;
            step();
            if (c == 0) bus0.req_valid = 1'b0;
        end
        chk("wr_rv_count", rvs, 4);

        // Abort in the fifth cycle of beat 2, then immediate new request.
        wait_idle();
        rvs = 0;
        req(1'b0, 16'h7A00, 3'd7);
        for (int c = 0; c <= 32; c++) begin
            if (c == 31) bus0.abort = 1'b1;
            if (c == 32) begin
                bus0.abort = 1'b0;
                req(1'b0, 16'h0200, 3'd0);
            end
            @(negedge clk);
            if (bus0.rd_valid === 1'b1) rvs++;
            chk("ab_done", bus0.done, 0);
            if (c == 32) begin
                chk("ab_en", {bus0.write_enable, bus0.read_enable}, 0);
                chk("ab_ready", bus0.req_ready, 1);
            end
            step();
            if (c == 0) bus0.req_valid = 1'b0;
        end
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("ab_new_re", bus0.read_enable, 1);
        chk("ab_new_addr", bus0.address, 16'h0200);
        chk("ab_rv_count", rvs, 2);
        step();

        // Reset asserted in the middle of beat 1 of a write.
        wait_idle();
        req(1'b1, 16'h3000, 3'd2);
        bus0.wr_data = 24'hABCDEF;
        step();
        bus0.req_valid = 1'b0;
        repeat (15) step();
        #1 n_rst = 1'b0;
        #1;
        chk("ar_ready", bus0.req_ready, 1);
        chk("ar_en", {bus0.write_enable, bus0.read_enable}, 0);
        chk("ar_addr", bus0.address, 0);
        chk("ar_wdata", bus0.w_data, 0);
        chk("ar_misc", {bus0.rd_valid, bus0.done, bus0.wr_data_ack}, 0);
        repeat (2) step();
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ar_post_ready", bus0.req_ready, 1);
            chk("ar_post_en", {bus0.write_enable, bus0.read_enable}, 0);
            step();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bus0.req_valid = ($urandom % 4 == 0);
            bus0.req_write = 1'($urandom);
            bus0.req_addr  = ($urandom % 8 == 0) ? ADDR_W'(16'hFFFC + $urandom % 4) : ADDR_W'($urandom);
            bus0.req_len   = LEN_W'($urandom);
            bus0.abort     = ($urandom % 64 == 0);
            bus0.wr_data   = DATA_W'($urandom);
            step();
        end
        bus0.req_valid = 1'b0;
        bus0.abort = 1'b0;
        wait_idle();

        // WAIT_CYCLES=1 instance with request held high.
        bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 16'h0020; bus1.req_len = 3'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("w1_ready", bus1.req_ready, (c % 3 == 0));
            chk("w1_re", bus1.read_enable, (c % 3 == 1));
            chk("w1_rv", bus1.rd_valid, (c % 3 == 2));
            chk("w1_done", bus1.done, (c % 3 == 2));
            if (c % 3 == 2) chk("w1_rdata", bus1.rd_data, 24'h0F0F0F);
            step();
        end
        bus1.req_valid = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
